// File: rtl/ls_memctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ls_memctrl_pkg / ls_memctrl_if
//  Description : Shared load/store opcodes and the bundled core/RAM signals
//                of the byte-serial load/store memory controller.
//  Revision    : 1.0 - initial release
// ============================================================================

package ls_memctrl_pkg;
  localparam logic [5:0] OP_LB  = 6'h01;
  localparam logic [5:0] OP_LH  = 6'h02;
  localparam logic [5:0] OP_LW  = 6'h03;
  localparam logic [5:0] OP_LBU = 6'h04;
  localparam logic [5:0] OP_LHU = 6'h05;
  localparam logic [5:0] OP_SB  = 6'h06;
  localparam logic [5:0] OP_SH  = 6'h07;
  localparam logic [5:0] OP_SW  = 6'h08;
endpackage

interface ls_memctrl_if;
  // global control
  logic        rdy;
  logic        rollback;
  // load request / return
  logic        load_store_sgn;
  logic [5:0]  load_store_op;
  logic [31:0] load_store_addr;
  logic        begin_real_load;
  logic        mem_valid;
  logic [31:0] mem_res;
  // store request / completion
  logic        store_req;
  logic [5:0]  store_op;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        finish_store;
  // byte-wide RAM / IO port
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  // controller side
  modport slave (
    input  rdy, rollback,
    input  load_store_sgn, load_store_op, load_store_addr,
    output begin_real_load, mem_valid, mem_res,
    input  store_req, store_op, store_addr, store_data,
    output finish_store,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  // core / RAM side
  modport master (
    output rdy, rollback,
    output load_store_sgn, load_store_op, load_store_addr,
    input  begin_real_load, mem_valid, mem_res,
    output store_req, store_op, store_addr, store_data,
    input  finish_store,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

`default_nettype wire

// File: rtl/ls_memctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ls_memctrl
//  Description : Byte-serial load/store controller. Loads and stores of 1, 2
//                or 4 bytes are split into little-endian byte transfers on a
//                RAM port with one cycle of read latency. Stores have priority,
//                stores to a full IO buffer are held off, rollback aborts
//                loads only, and rdy=0 freezes the whole block.
//  Revision    : 1.0 - initial release
// ============================================================================

module ls_memctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  ls_memctrl_if.slave bus
);
  import ls_memctrl_pkg::*;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;

  logic [1:0]  state_q,    state_d;
  logic [2:0]  cnt_q,      cnt_d;      // edges elapsed since the accept edge
  logic [5:0]  op_q,       op_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [31:0] rdata_q,    rdata_d;    // load bytes gathered so far
  logic        mem_wr_q,   mem_wr_d;
  logic [31:0] mem_a_q,    mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic [31:0] mem_res_q,  mem_res_d;
  logic        brl_q,      brl_d;
  logic        valid_q,    valid_d;
  logic        fin_q,      fin_d;

  logic [2:0]  w_nbytes;
  logic [2:0]  w_cnt_inc;
  logic [1:0]  w_rd_idx;
  logic [1:0]  w_wr_idx;
  logic        w_store_blocked;

  function automatic logic [2:0] op_bytes(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:         op_bytes = 3'd4;
      OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
      default:              op_bytes = 3'd1;
    endcase
  endfunction

  function automatic logic [31:0] op_extend(input logic [5:0] op, input logic [31:0] w);
    case (op)
      OP_LB:   op_extend = {{24{w[7]}}, w[7:0]};
      OP_LH:   op_extend = {{16{w[15]}}, w[15:0]};
      OP_LHU:  op_extend = {16'd0, w[15:0]};
      OP_LW:   op_extend = w;
      default: op_extend = {24'd0, w[7:0]};
    endcase
  endfunction

  assign w_nbytes        = op_bytes(op_q);
  assign w_cnt_inc       = cnt_q + 3'd1;
  // byte arriving on mem_din was addressed two edges ago
  assign w_rd_idx        = cnt_q[1:0] - 2'd1;
  assign w_wr_idx        = w_cnt_inc[1:0];
  assign w_store_blocked = (bus.store_addr >= IO_BASE) && bus.io_buffer_full;

  // State and datapath registers; rdy=0 freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      op_q       <= 6'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      mem_wr_q   <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_res_q  <= 32'd0;
      brl_q      <= 1'b0;
      valid_q    <= 1'b0;
      fin_q      <= 1'b0;
    end else if (bus.rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      mem_wr_q   <= mem_wr_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_res_q  <= mem_res_d;
      brl_q      <= brl_d;
      valid_q    <= valid_d;
      fin_q      <= fin_d;
    end
  end

  // Next state: store beats load, blocked IO store stalls everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.store_req) begin
          if (!w_store_blocked) state_d = ST_STORE;
        end else if (bus.load_store_sgn && !bus.rollback) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.rollback || (cnt_q == w_nbytes)) state_d = ST_IDLE;
      end
      ST_STORE: begin
        if (w_cnt_inc == w_nbytes) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next outputs and datapath values for the edge being taken
  always_comb begin
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mem_wr_d   = 1'b0;
    mem_a_d    = 32'd0;
    mem_dout_d = 8'd0;
    mem_res_d  = mem_res_q;
    brl_d      = 1'b0;
    valid_d    = 1'b0;
    fin_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_STORE) begin
          op_d       = bus.store_op;
          addr_d     = bus.store_addr;
          wdata_d    = bus.store_data;
          mem_wr_d   = 1'b1;
          mem_a_d    = bus.store_addr;
          mem_dout_d = bus.store_data[7:0];
        end else if (state_d == ST_LOAD) begin
          op_d    = bus.load_store_op;
          addr_d  = bus.load_store_addr;
          rdata_d = 32'd0;
          brl_d   = 1'b1;
          mem_a_d = bus.load_store_addr;
        end
      end
      ST_LOAD: begin
        if (!bus.rollback) begin
          cnt_d = w_cnt_inc;
          if (cnt_q != 3'd0) rdata_d[{w_rd_idx, 3'b000} +: 8] = bus.mem_din;
          if (w_cnt_inc < w_nbytes) mem_a_d = addr_q + {29'd0, w_cnt_inc};
          if (cnt_q == w_nbytes) begin
            valid_d   = 1'b1;
            mem_res_d = op_extend(op_q, rdata_d);
          end
        end
      end
      ST_STORE: begin
        cnt_d = w_cnt_inc;
        if (w_cnt_inc < w_nbytes) begin
          mem_wr_d   = 1'b1;
          mem_a_d    = addr_q + {29'd0, w_cnt_inc};
          mem_dout_d = wdata_q[{w_wr_idx, 3'b000} +: 8];
        end else begin
          fin_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d == ST_IDLE) cnt_d = 3'd0;
  end

  assign bus.mem_wr          = mem_wr_q;
  assign bus.mem_a           = mem_a_q;
  assign bus.mem_dout        = mem_dout_q;
  assign bus.mem_res         = mem_res_q;
  assign bus.begin_real_load = brl_q;
  assign bus.mem_valid       = valid_q;
  assign bus.finish_store    = fin_q;

endmodule

`default_nettype wire

// File: tb/tb_ls_memctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ls_memctrl
//  Description : Self-checking bench for ls_memctrl: byte RAM with one-cycle
//                read latency plus an array model of memory contents.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_ls_memctrl;
  import ls_memctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ls_memctrl_if bus ();

  ls_memctrl #(.IO_BASE(32'h0003_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // device RAM (1 KiB, aliased) and the bench's model of its contents
  logic [7:0] ram     [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic       pl_en;
  logic [9:0] pl_a;
  logic [7:0] pl_d;

  // synchronous byte RAM; shares the chip-wide rdy freeze
  always @(posedge clk) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (bus.rdy) begin
      if (bus.mem_wr) ram[bus.mem_a[9:0]] <= bus.mem_dout;
      bus.mem_din <= ram[bus.mem_a[9:0]];
    end
  end

  function automatic logic [9:0] m(input logic [31:0] a);
    return a[9:0];
  endfunction

  function automatic int nb(input logic [5:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] a);
    longint w = 0;
    for (int k = 0; k < nb(op); k++) w += longint'(ref_mem[m(a + 32'(k))]) << (8 * k);
    if (op == OP_LB && w >= 128)   w -= 256;
    if (op == OP_LH && w >= 32768) w -= 65536;
    return w[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // called just after the accept edge E0 of a load
  task automatic load_body(input logic [5:0] op, input logic [31:0] a, input int fk);
    int n;
    logic [31:0] e;
    n = nb(op);
    e = exp_load(op, a);
    check("load_a0", bus.mem_a, a);
    check("load_wr0", bus.mem_wr, 0);
    for (int k = 1; k <= n + 1; k++) begin
      tick();
      if (k == 1) check("brl_pulse", bus.begin_real_load, 0);
      if (k < n) check("load_addr", bus.mem_a, a + 32'(k));
      check("load_valid", bus.mem_valid, 32'(k == n + 1));
      check("load_wr", bus.mem_wr, 0);
      if (k == n + 1) begin
        check("load_data", bus.mem_res, e);
        check("load_idle_a", bus.mem_a, 0);
      end
      if (k == fk) begin
        bus.rdy = 1'b0;
        repeat (3) begin
          tick();
          if (k < n) check("frz_addr", bus.mem_a, a + 32'(k));
          check("frz_valid", bus.mem_valid, 32'(k == n + 1));
          if (k == n + 1) check("frz_data", bus.mem_res, e);
        end
        bus.rdy = 1'b1;
      end
    end
    tick();
    check("valid_pulse", bus.mem_valid, 0);
  endtask

  task automatic do_load(input logic [5:0] op, input logic [31:0] a, input int fk);
    bus.load_store_sgn  = 1'b1;
    bus.load_store_op   = op;
    bus.load_store_addr = a;
    tick();
    check("load_accept", bus.begin_real_load, 1);
    bus.load_store_sgn = 1'b0;
    load_body(op, a, fk);
  endtask

  // called just after the accept edge E0 of a store
  task automatic store_body(input logic [5:0] op, input logic [31:0] a,
                            input logic [31:0] d, input logic rb);
    int n;
    n = nb(op);
    bus.rollback = rb;
    for (int k = 0; k < n; k++) begin
      check("st_wr", bus.mem_wr, 1);
      check("st_addr", bus.mem_a, a + 32'(k));
      check("st_dout", bus.mem_dout, (d >> (8 * k)) & 32'hFF);
      check("st_fin_early", bus.finish_store, 0);
      tick();
    end
    check("st_fin", bus.finish_store, 1);
    check("st_wr_end", bus.mem_wr, 0);
    check("st_idle_a", bus.mem_a, 0);
    check("st_no_brl", bus.begin_real_load, 0);
    bus.store_req = 1'b0;
    bus.rollback  = 1'b0;
    for (int k = 0; k < n; k++) ref_mem[m(a + 32'(k))] = 8'((d >> (8 * k)) & 32'hFF);
    tick();
    check("st_fin_pulse", bus.finish_store, 0);
  endtask

  task automatic do_store(input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic rb);
    bus.store_req  = 1'b1;
    bus.store_op   = op;
    bus.store_addr = a;
    bus.store_data = d;
    tick();
    store_body(op, a, d, rb);
  endtask

  initial begin
    logic [5:0]  ops [0:7];
    logic [5:0]  op;
    logic [31:0] a, d;
    logic [7:0]  b;
    int          fk;
    ops[0] = OP_LB; ops[1] = OP_LH; ops[2] = OP_LW; ops[3] = OP_LBU;
    ops[4] = OP_LHU; ops[5] = OP_SB; ops[6] = OP_SH; ops[7] = OP_SW;

    rst_n               = 1'b0;
    bus.rdy             = 1'b1;
    bus.rollback        = 1'b0;
    bus.load_store_sgn  = 1'b0;
    bus.load_store_op   = 6'd0;
    bus.load_store_addr = 32'd0;
    bus.store_req       = 1'b0;
    bus.store_op        = 6'd0;
    bus.store_addr      = 32'd0;
    bus.store_data      = 32'd0;
    bus.io_buffer_full  = 1'b0;
    pl_en               = 1'b0;
    pl_a                = 10'd0;
    pl_d                = 8'd0;

    // preload RAM and model while reset is held
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      case (i)
        'h100: b = 8'h80;
        'h010: b = 8'h34;
        'h011: b = 8'h12;
        'h020: b = 8'h78;
        'h021: b = 8'h56;
        'h022: b = 8'h34;
        'h023: b = 8'h12;
        default: ;
      endcase
      pl_en = 1'b1;
      pl_a  = 10'(i);
      pl_d  = b;
      ref_mem[i] = b;
      tick();
    end
    pl_en = 1'b0;

    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_mem_a", bus.mem_a, 0);
    check("rst_mem_dout", bus.mem_dout, 0);
    check("rst_mem_res", bus.mem_res, 0);
    check("rst_brl", bus.begin_real_load, 0);
    check("rst_valid", bus.mem_valid, 0);
    check("rst_fin", bus.finish_store, 0);
    rst_n = 1'b1;
    tick();

    // basic loads and extension
    do_load(OP_LB,  32'h100, 0);
    do_load(OP_LBU, 32'h100, 0);
    do_load(OP_LHU, 32'h010, 0);
    do_load(OP_LH,  32'h010, 0);
    do_load(OP_LW,  32'h020, 0);

    // word store then read back
    do_store(OP_SW, 32'h200, 32'hDEADBEEF, 1'b0);
    do_load(OP_LW, 32'h200, 0);

    // store wins over simultaneous load; load follows after one IDLE cycle
    bus.store_req = 1'b1; bus.store_op = OP_SW; bus.store_addr = 32'h240; bus.store_data = 32'h8001_7F02;
    bus.load_store_sgn = 1'b1; bus.load_store_op = OP_LH; bus.load_store_addr = 32'h240;
    tick();
    check("prio_no_load", bus.begin_real_load, 0);
    store_body(OP_SW, 32'h240, 32'h8001_7F02, 1'b0);
    check("prio_load_after", bus.begin_real_load, 1);
    bus.load_store_sgn = 1'b0;
    load_body(OP_LH, 32'h240, 0);

    // IO store held off while the buffer is full, pending load not taken
    bus.store_req = 1'b1; bus.store_op = OP_SB; bus.store_addr = 32'h30000; bus.store_data = 32'h0000_00A5;
    bus.io_buffer_full = 1'b1;
    bus.load_store_sgn = 1'b1; bus.load_store_op = OP_LB; bus.load_store_addr = 32'h100;
    repeat (3) begin
      tick();
      check("io_full_no_wr", bus.mem_wr, 0);
      check("io_full_no_load", bus.begin_real_load, 0);
    end
    bus.io_buffer_full = 1'b0;
    tick();
    check("io_no_load", bus.begin_real_load, 0);
    store_body(OP_SB, 32'h30000, 32'h0000_00A5, 1'b0);
    check("io_load_after", bus.begin_real_load, 1);
    bus.load_store_sgn = 1'b0;
    load_body(OP_LB, 32'h100, 0);

    // rollback in IDLE blocks a load for that edge only
    bus.load_store_sgn = 1'b1; bus.load_store_op = OP_LBU; bus.load_store_addr = 32'h011;
    bus.rollback = 1'b1;
    tick();
    check("rb_idle_block", bus.begin_real_load, 0);
    bus.rollback = 1'b0;
    tick();
    check("rb_idle_accept", bus.begin_real_load, 1);
    bus.load_store_sgn = 1'b0;
    load_body(OP_LBU, 32'h011, 0);

    // rollback after E2 of a word load aborts it
    bus.load_store_sgn = 1'b1; bus.load_store_op = OP_LW; bus.load_store_addr = 32'h020;
    tick();
    check("rb_load_accept", bus.begin_real_load, 1);
    bus.load_store_sgn = 1'b0;
    tick();
    tick();
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    check("rb_load_a", bus.mem_a, 0);
    check("rb_load_wr", bus.mem_wr, 0);
    repeat (5) begin
      check("rb_load_valid", bus.mem_valid, 0);
      tick();
    end
    do_load(OP_LW, 32'h020, 0);

    // rollback mid-store is ignored
    do_store(OP_SW, 32'h280, $urandom, 1'b1);
    do_load(OP_LW, 32'h280, 0);

    // rdy freeze mid-load and with the result strobe pending
    do_load(OP_LW, 32'h200, 2);
    do_load(OP_LH, 32'h010, 3);

    // asynchronous reset in the middle of a word store
    d = $urandom;
    bus.store_req = 1'b1; bus.store_op = OP_SW; bus.store_addr = 32'h300; bus.store_data = d;
    tick();
    check("rs_accept", bus.mem_wr, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("rs_wr_drop", bus.mem_wr, 0);
    check("rs_a", bus.mem_a, 0);
    check("rs_dout", bus.mem_dout, 0);
    check("rs_fin", bus.finish_store, 0);
    bus.store_req = 1'b0;
    ref_mem[m(32'h300)] = d[7:0];
    tick();
    check("rs_fin_hold", bus.finish_store, 0);
    rst_n = 1'b1;
    tick();
    check("rs_after_wr", bus.mem_wr, 0);
    check("rs_after_fin", bus.finish_store, 0);
    do_load(OP_LW, 32'h300, 0);

    // randomized mix against the memory model
    for (int it = 0; it < 40; it++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = 32'($urandom_range(0, 1023));
      if (op == OP_SB || op == OP_SH || op == OP_SW) begin
        do_store(op, a, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        fk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb(op) + 1) : 0;
        do_load(op, a, fk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
